ascon_bd_sequencer: RTL
=======================

Name: ascon_bd_sequencer

Overview:
- Host-side controller for the Ascon engine's 16-bit toggle-handshake port (bd_in_data/bd_in_config, bd_out_data/bd_out_config).
- Accepts one 128-bit block command per valid/ready handshake.
- Serialises the block MSB-first into 1..8 engine beats, collects the engine's returned halfwords into a 128-bit response, and reports auth and timeout status.
- Replaces hand-sequenced toggle traffic from the processor side of the PYNQ design.

Parameters:
TIMEOUT_CYCLES, 1024, WAIT cycles without acknowledge before a beat is abandoned (timer width = clog2(TIMEOUT_CYCLES+1))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_type  in  4  engine command type (CONF/KEY/NONCE/TAG/AD/SKIP_AD/PLAIN/CIPHER/OK codes)
cmd_flags  in  5  copied to bd_in_config[5:1] on every beat
cmd_beats  in  4  beats to send, 1..8; 0 or >8 treated as 8
cmd_data  in  128  payload; beat k carries cmd_data[127-16k -: 16]
rsp_valid  out  1  response ready
rsp_ready  in  1  host consumes response
rsp_data  out  128  returned halfwords, shifted in at LSB (first beat ends most significant)
rsp_auth  out  1  bd_out_config[3] sampled at final acknowledge
rsp_err  out  1  command ended by timeout
bd_in_data  out  16  to engine
bd_in_config  out  16  to engine: [15:11]=0, [10:7]=type, [6]=last, [5:1]=flags, [0]=toggle
bd_out_data  in  16  from engine
bd_out_config  in  16  from engine: [3]=auth, [2]=toggle

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; bd_in_data=0, bd_in_config=0, rsp_valid=0, rsp_data=0, rsp_auth=0, rsp_err=0; beat counter, timer and shift registers=0. cmd_ready=1 (decoded from state).
- State IDLE:
  - On cmd_valid&&cmd_ready: latch payload, type, flags and beats (clamped); go to WAIT.
  - On that same edge, drive beat 0: bd_in_data=payload[127:112]; last=(beats==1); toggle=T, where T is bd_out_config[2] sampled that cycle.
- Toggle protocol:
  - A beat is issued with toggle T equal to the engine's current out toggle.
  - The beat is acknowledged when bd_out_config[2]!=T.
  - The next beat's T is the newly sampled bd_out_config[2]. This self-resynchronises after errors.
- State WAIT:
  - bd_in_* are held stable and the timer increments.
  - On acknowledge: rsp_data<={rsp_data[111:0],bd_out_data}; timer clears.
  - If the acknowledged beat was not last: drive the next beat on the same edge (payload shifted left 16; last=1 on beat beats-1) and stay in WAIT. Throughput is engine latency + 1 cycle per beat.
  - If it was last: capture rsp_auth=bd_out_config[3], rsp_err=0, rsp_valid=1; go to RESP.
  - If the timer reaches TIMEOUT_CYCLES without acknowledge: rsp_err=1, rsp_auth=0, rsp_valid=1; go to RESP. rsp_data holds the beats collected so far.
  - Acknowledge and timeout in the same cycle: acknowledge wins.
- State RESP:
  - rsp_* are held until rsp_ready. On the handshake: rsp_valid=0, rsp_data cleared, go to IDLE.
  - cmd_ready=0 in RESP (no overlap).
  - bd_in_* keep their last beat values; the engine must not see a spurious toggle change.
- Engine toggle changes while in IDLE/RESP are ignored; T is always re-sampled at issue time.
- Reset mid-command: everything returns to reset values immediately. In-flight data is lost; bd_in_config drops to 0.
- rsp_data for cmd_beats<8 holds only the returned beats in its low bits; upper bits are 0.

Decomposition:
- Shared header (the existing constants include): command type codes and the config bit-position constants (CFG_TYPE_LSB=7, CFG_LAST=6, CFG_TOGGLE=0, OUT_AUTH=3, OUT_TOGGLE=2).
- Single module; no natural sub-module. Timer and beat counter are inline.

Test Plan:
- Reset values: hold rst low 2 cycles → all outputs 0, cmd_ready=1. Reset asserted mid-WAIT → immediate return to those values.
- KEY block: engine model acks 3 cycles after each toggle change; cmd_type=KEY, beats=8, data=000102030405060708090A0B0C0D0E0F → bd_in_data sequence 0001,0203,…,0E0F. last=1 only on the 8th beat. Toggles alternate starting from the engine's out toggle.
- Single-beat CONF: beats=1, flags=5'b01100 → bd_in_config[6]=1 on the only beat, [5:1]=01100; rsp_valid after one ack.
- CIPHER→OK decrypt flow: model returns 8000,0000×7 on the OK block → rsp_data=80000000000000000000000000000000. Model drives out[3]=1 → rsp_auth=1.
- Timeout: model stops acking after beat 2, TIMEOUT_CYCLES=16 → rsp_err=1 exactly 16 cycles after beat 3 issue, rsp_data low 32 bits = beats 0-1. The next command issues its first beat with toggle equal to the engine's current out toggle.
- Backpressure/race: hold rsp_ready=0 for 10 cycles → rsp stable, cmd_ready=0. Ack coincident with timer terminal count → completes normally with rsp_err=0.

Source files
------------

// File: rtl/ascon_bd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ascon_bd_sequencer_pkg
// Shared constants for the host-side Ascon toggle-handshake sequencer:
//   - engine command type codes carried in bd_in_config[10:7]
//   - bit positions inside bd_in_config / bd_out_config
//   - sequencer state encoding
//   - helpers for beat-count clamping and config word assembly
// -----------------------------------------------------------------------------
package ascon_bd_sequencer_pkg;

  // Engine command type codes (4-bit field of bd_in_config)
  localparam logic [3:0] CMD_CONF    = 4'h0;
  localparam logic [3:0] CMD_KEY     = 4'h1;
  localparam logic [3:0] CMD_NONCE   = 4'h2;
  localparam logic [3:0] CMD_TAG     = 4'h3;
  localparam logic [3:0] CMD_AD      = 4'h4;
  localparam logic [3:0] CMD_SKIP_AD = 4'h5;
  localparam logic [3:0] CMD_PLAIN   = 4'h6;
  localparam logic [3:0] CMD_CIPHER  = 4'h7;
  localparam logic [3:0] CMD_OK      = 4'h8;

  // Config bit positions
  localparam int CFG_TYPE_LSB  = 7;
  localparam int CFG_LAST      = 6;
  localparam int CFG_FLAGS_LSB = 1;
  localparam int CFG_TOGGLE    = 0;
  localparam int OUT_AUTH      = 3;
  localparam int OUT_TOGGLE    = 2;

  localparam logic [3:0] MAX_BEATS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } seq_state_e;

  // A beat count of 0 or above 8 means a full 8-beat block
  function automatic logic [3:0] clamp_beats(input logic [3:0] beats);
    logic [3:0] result;
    if ((beats == 4'd0) || (beats > MAX_BEATS)) begin
      result = MAX_BEATS;
    end else begin
      result = beats;
    end
    return result;
  endfunction

  // bd_in_config layout: [15:11]=0, [10:7]=type, [6]=last, [5:1]=flags, [0]=toggle
  function automatic logic [15:0] make_config(input logic [3:0] cmd_type,
                                              input logic       last,
                                              input logic [4:0] flags,
                                              input logic       toggle);
    return {5'b00000, cmd_type, last, flags, toggle};
  endfunction

endpackage

// File: rtl/ascon_bd_sequencer.sv
// -----------------------------------------------------------------------------
// ascon_bd_sequencer
// Takes one 128-bit block command per valid/ready handshake, sends it MSB-first
// to the Ascon engine as 1..8 toggle-handshake beats, gathers the returned
// halfwords into a 128-bit response and reports auth / timeout status.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_type/flags/beats  engine type code, config flags, beat count (0,>8 -> 8)
//   cmd_data              128-bit payload, beat k = cmd_data[127-16k -: 16]
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/auth/err     collected halfwords, auth bit at final ack, timeout flag
//   bd_in_data/config     beat towards the engine
//   bd_out_data/config    engine return halfword, [3]=auth, [2]=toggle
// -----------------------------------------------------------------------------
module ascon_bd_sequencer
  import ascon_bd_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_type,
  input  logic [4:0]   cmd_flags,
  input  logic [3:0]   cmd_beats,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_auth,
  output logic         rsp_err,
  output logic [15:0]  bd_in_data,
  output logic [15:0]  bd_in_config,
  input  logic [15:0]  bd_out_data,
  input  logic [15:0]  bd_out_config
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Terminal compare is one below the limit: the edge that would make the
  // timer reach TIMEOUT_CYCLES is the edge that abandons the beat.
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CYCLES - 1);

  seq_state_e     state_q, state_d;
  logic [127:0]   payload_q, payload_d;   // beats not yet sent, left-aligned
  logic [3:0]     type_q, type_d;
  logic [4:0]     flags_q, flags_d;
  logic [3:0]     beats_q, beats_d;
  logic [3:0]     beat_idx_q, beat_idx_d; // index of beat currently in flight
  logic           tog_q, tog_d;           // toggle T of the beat in flight
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   rsp_data_q, rsp_data_d;
  logic           rsp_auth_q, rsp_auth_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [15:0]    bd_data_q, bd_data_d;
  logic [15:0]    bd_cfg_q, bd_cfg_d;

  logic           ack_s;
  logic           last_s;
  logic           next_last_s;
  logic [3:0]     beats_clamped_s;
  logic           out_tog_s;

  assign out_tog_s       = bd_out_config[OUT_TOGGLE];
  assign ack_s           = (out_tog_s != tog_q);
  assign last_s          = (beat_idx_q == (beats_q - 4'd1));
  assign next_last_s     = ((beat_idx_q + 4'd1) == (beats_q - 4'd1));
  assign beats_clamped_s = clamp_beats(cmd_beats);

  // Next-state and next-output computation for the beat sequencer
  always_comb begin
    state_d    = state_q;
    payload_d  = payload_q;
    type_d     = type_q;
    flags_d    = flags_q;
    beats_d    = beats_q;
    beat_idx_d = beat_idx_q;
    tog_d      = tog_q;
    timer_d    = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_auth_d = rsp_auth_q;
    rsp_err_d  = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    bd_data_d  = bd_data_q;
    bd_cfg_d   = bd_cfg_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Beat 0 goes out on the accepting edge with T = current engine toggle
          type_d     = cmd_type;
          flags_d    = cmd_flags;
          beats_d    = beats_clamped_s;
          payload_d  = {cmd_data[111:0], 16'h0000};
          beat_idx_d = 4'd0;
          tog_d      = out_tog_s;
          timer_d    = '0;
          rsp_data_d = 128'd0;
          bd_data_d  = cmd_data[127:112];
          bd_cfg_d   = make_config(cmd_type, (beats_clamped_s == 4'd1),
                                   cmd_flags, out_tog_s);
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (ack_s) begin
          rsp_data_d = {rsp_data_q[111:0], bd_out_data};
          timer_d    = '0;
          if (last_s) begin
            rsp_auth_d  = bd_out_config[OUT_AUTH];
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            // Next beat adopts the freshly sampled engine toggle, so a stray
            // toggle from an earlier error never desynchronises us.
            beat_idx_d = beat_idx_q + 4'd1;
            bd_data_d  = payload_q[127:112];
            payload_d  = {payload_q[111:0], 16'h0000};
            tog_d      = out_tog_s;
            bd_cfg_d   = make_config(type_q, next_last_s, flags_q, out_tog_s);
          end
        end else if (timer_q == TIMER_TERM) begin
          rsp_err_d   = 1'b1;
          rsp_auth_d  = 1'b0;
          rsp_valid_d = 1'b1;
          timer_d     = '0;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end

      ST_RESP: begin
        // bd_in_* keep the last beat so the engine sees no toggle edge
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = 128'd0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      payload_q   <= 128'd0;
      type_q      <= 4'd0;
      flags_q     <= 5'd0;
      beats_q     <= 4'd0;
      beat_idx_q  <= 4'd0;
      tog_q       <= 1'b0;
      timer_q     <= '0;
      rsp_data_q  <= 128'd0;
      rsp_auth_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      bd_data_q   <= 16'd0;
      bd_cfg_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      payload_q   <= payload_d;
      type_q      <= type_d;
      flags_q     <= flags_d;
      beats_q     <= beats_d;
      beat_idx_q  <= beat_idx_d;
      tog_q       <= tog_d;
      timer_q     <= timer_d;
      rsp_data_q  <= rsp_data_d;
      rsp_auth_q  <= rsp_auth_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      bd_data_q   <= bd_data_d;
      bd_cfg_q    <= bd_cfg_d;
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_auth     = rsp_auth_q;
  assign rsp_err      = rsp_err_q;
  assign bd_in_data   = bd_data_q;
  assign bd_in_config = bd_cfg_q;

endmodule
